// File: rtl/uart_rx_frame_engine_if.sv
// uart_rx_frame_engine_if: received-word handshake and status bundle
interface uart_rx_frame_engine_if #(parameter int W = 9);
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         frame_error;
    logic         parity_error;
    logic         break_detect;
    logic         overrun_error;
    modport master (
        output rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error,
        input  rx_ready
    );
    modport slave (
        input  rx_data, rx_valid, frame_error, parity_error, break_detect, overrun_error,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame_engine.sv
// uart_rx_frame_engine: oversampled UART receiver with parity, stop, break and overrun handling
module uart_rx_frame_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic [4:0] data_bits,
    input  logic [1:0] parity_mode,
    input  logic       stop_bits,
    output logic       busy,
    uart_rx_frame_engine_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, REARM} state_t;
    state_t                   state;
    logic                     rx_s1, rx_s2, rx_q;
    logic [TW-1:0]            tick_cnt;
    logic [1:0]               votes;
    logic [MAX_DATA_BITS-1:0] shreg;
    logic [4:0]               bit_cnt, nbits;
    logic [1:0]               pmode;
    logic                     sbits, par_acc, perr, ferr, all_zero;
    logic                     mid_a, mid_b, mid_c, bit_end, maj, last_stop, fe_final, brk_final;
    logic [4:0]               nbits_in;
    logic                     par_exp;
    assign busy      = state != IDLE;
    assign mid_a     = baud_tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1);
    assign mid_b     = baud_tick && tick_cnt == TW'(OVERSAMPLE / 2);
    assign mid_c     = baud_tick && tick_cnt == TW'(OVERSAMPLE / 2 + 1);
    assign bit_end   = baud_tick && tick_cnt == TW'(OVERSAMPLE - 1);
    assign maj       = (votes[0] & votes[1]) | (votes[0] & rx_s2) | (votes[1] & rx_s2);
    assign last_stop = mid_c && ((state == STOP1 && !sbits) || state == STOP2);
    assign fe_final  = ferr | ~maj;
    assign brk_final = all_zero & ~maj;
    assign nbits_in  = data_bits < 5'd5 ? 5'd5 :
                       data_bits > 5'(MAX_DATA_BITS) ? 5'(MAX_DATA_BITS) : data_bits;
    assign par_exp   = pmode == 2'b01 ? ~par_acc : pmode == 2'b10 ? par_acc : 1'b1;
    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end
    // frame FSM: bit timing, majority sampling, status accumulation and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tick_cnt         <= '0;
            votes            <= '0;
            shreg            <= '0;
            bit_cnt          <= '0;
            nbits            <= 5'd5;
            pmode            <= '0;
            sbits            <= 1'b0;
            par_acc          <= 1'b0;
            perr             <= 1'b0;
            ferr             <= 1'b0;
            all_zero         <= 1'b0;
            rx.rx_data       <= '0;
            rx.rx_valid      <= 1'b0;
            rx.frame_error   <= 1'b0;
            rx.parity_error  <= 1'b0;
            rx.break_detect  <= 1'b0;
            rx.overrun_error <= 1'b0;
        end else begin
            rx.overrun_error <= 1'b0;
            if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
            if (last_stop) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_valid     <= 1'b1;
                    rx.rx_data      <= brk_final ? '0 : shreg >> (5'(MAX_DATA_BITS) - nbits);
                    rx.frame_error  <= fe_final;
                    rx.parity_error <= perr;
                    rx.break_detect <= brk_final;
                end else begin
                    rx.overrun_error <= 1'b1;
                end
                state <= fe_final ? REARM : IDLE;
            end
            if (baud_tick && state != IDLE && state != REARM) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
                if (mid_a) votes[0] <= rx_s2;
                if (mid_b) votes[1] <= rx_s2;
            end
            case (state)
                IDLE: if (rx_q && !rx_s2) begin
                    state    <= START;
                    tick_cnt <= '0;
                    nbits    <= nbits_in;
                    pmode    <= parity_mode;
                    sbits    <= stop_bits;
                    shreg    <= '0;
                    bit_cnt  <= '0;
                    par_acc  <= 1'b0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                    all_zero <= 1'b1;
                end
                START: begin
                    if (mid_c && maj) state <= IDLE;
                    else if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (mid_c) begin
                        shreg    <= {maj, shreg[MAX_DATA_BITS-1:1]};
                        par_acc  <= par_acc ^ maj;
                        all_zero <= all_zero & ~maj;
                        bit_cnt  <= bit_cnt + 5'd1;
                    end
                    if (bit_end && bit_cnt == nbits) state <= pmode != 2'b00 ? PARITY : STOP1;
                end
                PARITY: begin
                    if (mid_c) begin
                        perr     <= maj != par_exp;
                        all_zero <= all_zero & ~maj;
                    end
                    if (bit_end) state <= STOP1;
                end
                STOP1: begin
                    if (mid_c) begin
                        ferr     <= ferr | ~maj;
                        all_zero <= all_zero & ~maj;
                    end
                    if (bit_end) state <= STOP2;
                end
                STOP2: ;
                REARM: if (rx_s2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// tb_uart_rx_frame_engine: directed frames with hand-computed expectations
module tb_uart_rx_frame_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b1;
    logic       rxd = 1'b1;
    logic [4:0] data_bits = 5'd8;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bits = 1'b0;
    logic       busy;
    int         total = 0;
    int         bad = 0;
    int         ov_cycles = 0;
    uart_rx_frame_engine_if #(.W(9)) bus ();
    uart_rx_frame_engine #(.MAX_DATA_BITS(9), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rxd(rxd),
        .data_bits(data_bits), .parity_mode(parity_mode), .stop_bits(stop_bits),
        .busy(busy), .rx(bus.master)
    );
    always #5 clk = ~clk;
    // count cycles during which the overrun pulse is high
    always @(negedge clk) if (bus.overrun_error) ov_cycles++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [31:0] bits, input int n, input bit scramble);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            if (scramble && i == 1) begin
                data_bits = 5'd16;
                parity_mode = 2'b00;
                stop_bits = 1'b1;
            end
            repeat (16) @(negedge clk);
        end
    endtask
    task automatic ack();
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask
    initial begin
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.rx_valid), 0);
        chk("rst_data", 32'(bus.rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, bus.frame_error, bus.parity_error, bus.break_detect}, 0);
        chk("rst_ovr", 32'(bus.overrun_error), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // 8N1 0xA5
        send({22'd0, 1'b1, 8'hA5, 1'b0}, 10, 0);
        repeat (4) @(negedge clk);
        chk("a5_valid", 32'(bus.rx_valid), 1);
        chk("a5_data", 32'(bus.rx_data), 32'h0A5);
        chk("a5_fe", 32'(bus.frame_error), 0);
        chk("a5_pe", 32'(bus.parity_error), 0);
        chk("a5_brk", 32'(bus.break_detect), 0);
        chk("a5_busy", 32'(busy), 0);
        ack();
        chk("a5_ack", 32'(bus.rx_valid), 0);
        // 7E1 0x27, wrong parity bit 1
        data_bits = 5'd7; parity_mode = 2'b10; stop_bits = 1'b0;
        send({22'd0, 1'b1, 1'b1, 7'h27, 1'b0}, 10, 0);
        repeat (4) @(negedge clk);
        chk("e7_valid", 32'(bus.rx_valid), 1);
        chk("e7_data", 32'(bus.rx_data), 32'h027);
        chk("e7_pe", 32'(bus.parity_error), 1);
        chk("e7_fe", 32'(bus.frame_error), 0);
        ack();
        // 7E1 0x27, correct parity bit 0, config changed mid-frame
        send({22'd0, 1'b1, 1'b0, 7'h27, 1'b0}, 10, 1);
        repeat (4) @(negedge clk);
        chk("e7ok_valid", 32'(bus.rx_valid), 1);
        chk("e7ok_data", 32'(bus.rx_data), 32'h027);
        chk("e7ok_pe", 32'(bus.parity_error), 0);
        ack();
        // 9O2 0x155, second stop bit 0, line left low
        data_bits = 5'd9; parity_mode = 2'b01; stop_bits = 1'b1;
        send({19'd0, 1'b0, 1'b1, 1'b0, 9'h155, 1'b0}, 13, 0);
        chk("o9_valid", 32'(bus.rx_valid), 1);
        chk("o9_data", 32'(bus.rx_data), 32'h155);
        chk("o9_fe", 32'(bus.frame_error), 1);
        chk("o9_pe", 32'(bus.parity_error), 0);
        chk("o9_brk", 32'(bus.break_detect), 0);
        repeat (10) @(negedge clk);
        chk("o9_rearm_busy", 32'(busy), 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("o9_idle_busy", 32'(busy), 0);
        ack();
        // false start: 6 ticks low
        data_bits = 5'd8; parity_mode = 2'b00; stop_bits = 1'b0;
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        chk("fs_busy_mid", 32'(busy), 1);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("fs_valid", 32'(bus.rx_valid), 0);
        chk("fs_busy", 32'(busy), 0);
        // overrun: two frames, no acknowledge
        ov_cycles = 0;
        send({22'd0, 1'b1, 8'h11, 1'b0}, 10, 0);
        send({22'd0, 1'b1, 8'h22, 1'b0}, 10, 0);
        repeat (4) @(negedge clk);
        chk("ov_data", 32'(bus.rx_data), 32'h011);
        chk("ov_valid", 32'(bus.rx_valid), 1);
        chk("ov_pulse", 32'(ov_cycles), 1);
        ack();
        // break: 12 bit periods low on 8E1
        parity_mode = 2'b10;
        send(32'd0, 12, 0);
        chk("brk_valid", 32'(bus.rx_valid), 1);
        chk("brk_brk", 32'(bus.break_detect), 1);
        chk("brk_fe", 32'(bus.frame_error), 1);
        chk("brk_data", 32'(bus.rx_data), 0);
        chk("brk_busy", 32'(busy), 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("brk_idle", 32'(busy), 0);
        // reset mid-frame (frame left unacknowledged so outputs are nonzero)
        parity_mode = 2'b00;
        send({28'd0, 3'b101, 1'b0}, 4, 0);
        rst_n = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        chk("mr_valid", 32'(bus.rx_valid), 0);
        chk("mr_data", 32'(bus.rx_data), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_flags", {29'd0, bus.frame_error, bus.parity_error, bus.break_detect}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mr_after_valid", 32'(bus.rx_valid), 0);
        chk("mr_after_busy", 32'(busy), 0);
        send({22'd0, 1'b1, 8'h3C, 1'b0}, 10, 0);
        repeat (4) @(negedge clk);
        chk("post_data", 32'(bus.rx_data), 32'h03C);
        chk("post_valid", 32'(bus.rx_valid), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
